// File: rtl/alu_operand_pkg.sv
// ----------------------------------------------------------------------------
// alu_operand_pkg
// Shared constants for the ALU operand stage: Beta instruction field
// positions, opcode and function-field encodings, ALU function codes, the
// registered output bundle type and a literal sign-extension helper.
// Optional feature macro used by the stage: ALU_OPERAND_BYPASS_EN.
// ----------------------------------------------------------------------------
package alu_operand_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Instruction field slices
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RC_HI  = 25;
    localparam int RC_LO  = 21;
    localparam int RA_HI  = 20;
    localparam int RA_LO  = 16;
    localparam int RB_HI  = 15;
    localparam int RB_LO  = 11;
    localparam int LIT_HI = 15;
    localparam int LIT_LO = 0;

    // ALU function codes
    localparam logic [5:0] ALUFN_ADD   = 6'b000000;
    localparam logic [5:0] ALUFN_SUB   = 6'b000001;
    localparam logic [5:0] ALUFN_MUL   = 6'b000010;
    localparam logic [5:0] ALUFN_CMPEQ = 6'b110011;
    localparam logic [5:0] ALUFN_CMPLT = 6'b110101;
    localparam logic [5:0] ALUFN_CMPLE = 6'b110111;
    localparam logic [5:0] ALUFN_AND   = 6'b011000;
    localparam logic [5:0] ALUFN_OR    = 6'b011110;
    localparam logic [5:0] ALUFN_XOR   = 6'b010110;
    localparam logic [5:0] ALUFN_SHL   = 6'b100000;
    localparam logic [5:0] ALUFN_SHR   = 6'b100001;
    localparam logic [5:0] ALUFN_SRA   = 6'b100011;

    // Low four opcode bits of the OP (10xxxx) / OPC (11xxxx) classes
    localparam logic [3:0] FN_ADD   = 4'h0;
    localparam logic [3:0] FN_SUB   = 4'h1;
    localparam logic [3:0] FN_MUL   = 4'h2;
    localparam logic [3:0] FN_CMPEQ = 4'h4;
    localparam logic [3:0] FN_CMPLT = 4'h5;
    localparam logic [3:0] FN_CMPLE = 4'h6;
    localparam logic [3:0] FN_AND   = 4'h8;
    localparam logic [3:0] FN_OR    = 4'h9;
    localparam logic [3:0] FN_XOR   = 4'hA;
    localparam logic [3:0] FN_SHL   = 4'hC;
    localparam logic [3:0] FN_SHR   = 4'hD;
    localparam logic [3:0] FN_SRA   = 4'hE;

    // Memory-class opcodes (address computed as Ra + sext(literal))
    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_LDR = 6'b011111;

    typedef struct packed {
        logic [5:0]        alufn;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rc;
        logic              wr_en;
        logic              illegal;
    } alu_bundle_t;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] lit);
        return {{(DATA_W-16){lit[15]}}, lit};
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// ----------------------------------------------------------------------------
// alu_operand_stage_if
// Instruction-in / bundle-out handshake bus of the ALU operand stage.
//   slave  : view of the stage (consumes instructions, produces bundles)
//   master : view of the upstream/downstream environment
// Signals: in_valid, in_ready, in_instr, out_valid, out_ready, out_alufn,
//          out_a, out_b, out_rc, out_wr_en, out_illegal.
// ----------------------------------------------------------------------------
interface alu_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_alufn;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rc;
    logic        out_wr_en;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alufn, out_a, out_b, out_rc,
               out_wr_en, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alufn, out_a, out_b, out_rc,
               out_wr_en, out_illegal
    );
endinterface

// File: rtl/alu_regfile.sv
// ----------------------------------------------------------------------------
// alu_regfile
// NREGS x DATA_W register file, two combinational read ports, one write
// port. The last register (R31) is hard-wired to zero: writes to it are
// dropped and reads of it return 0. Asynchronous active-low reset clears
// every register.
// Ports: clk, rst_n, ra_addr/ra_data, rb_addr/rb_data, we/wa/wd.
// ----------------------------------------------------------------------------
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);
    localparam logic [AW-1:0] ZERO_IDX = AW'(NREGS - 1);

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [AW-1:0]     rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (wa != ZERO_IDX)) begin
            regs_reg[wa] <= wd;
        end
    end

    assign rd_addr[0] = ra_addr;
    assign rd_addr[1] = rb_addr;

    // The zero register is also masked on read so it never depends on
    // the storage element behind it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_data[gi] = (rd_addr[gi] == ZERO_IDX) ? '0 : regs_reg[rd_addr[gi]];
        end
    endgenerate

    assign ra_data = rd_data[0];
    assign rb_data = rd_data[1];
endmodule

// File: rtl/alu_operand_stage.sv
// ----------------------------------------------------------------------------
// alu_operand_stage
// Decode / operand-fetch stage in front of the ALU. Accepts one Beta
// instruction per handshake, reads Ra/Rb from the register file, decodes the
// opcode into an ALU function code, selects operand b (Rb or sign-extended
// literal) and presents a registered bundle to the ALU. ALU results return
// through the wb_* write port.
// Ports: clk, rst_n (async active-low), bus (alu_operand_stage_if.slave),
//        wb_en / wb_addr / wb_data.
// Optional feature macro: ALU_OPERAND_BYPASS_EN -- forward a same-cycle
// write-back into the operands being read. Without it the operands see the
// pre-write register value.
// ----------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_operand_stage_if.slave        bus,
    input  logic                      wb_en,
    input  logic [4:0]                wb_addr,
    input  logic [31:0]               wb_data
);
    localparam logic [4:0] ZERO_IDX = 5'(NREGS - 1);

    logic [5:0]        opcode;
    logic [3:0]        fn;
    logic [4:0]        ra_idx;
    logic [4:0]        rb_idx;
    logic [4:0]        rc_idx;
    logic [31:0]       lit_ext;
    logic [31:0]       ra_rf;
    logic [31:0]       rb_rf;
    logic [31:0]       ra_val;
    logic [31:0]       rb_val;
    logic [5:0]        fn_alufn;
    logic              fn_ok;
    logic              load;
    alu_bundle_t       bundle_next;
    alu_bundle_t       bundle_reg;
    logic              valid_reg;

    assign opcode  = bus.in_instr[OPC_HI:OPC_LO];
    assign fn      = opcode[3:0];
    assign ra_idx  = bus.in_instr[RA_HI:RA_LO];
    assign rb_idx  = bus.in_instr[RB_HI:RB_LO];
    assign rc_idx  = bus.in_instr[RC_HI:RC_LO];
    assign lit_ext = sext16(bus.in_instr[LIT_HI:LIT_LO]);

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ra_idx),
        .rb_addr (rb_idx),
        .ra_data (ra_rf),
        .rb_data (rb_rf),
        .we      (wb_en),
        .wa      (wb_addr),
        .wd      (wb_data)
    );

`ifdef ALU_OPERAND_BYPASS_EN
    assign ra_val = (wb_en && (wb_addr == ra_idx) && (ra_idx != ZERO_IDX)) ? wb_data : ra_rf;
    assign rb_val = (wb_en && (wb_addr == rb_idx) && (rb_idx != ZERO_IDX)) ? wb_data : rb_rf;
`else
    assign ra_val = ra_rf;
    assign rb_val = rb_rf;
`endif

    // Function field shared by the OP and OPC classes; holes are illegal.
    always_comb begin
        fn_ok    = 1'b1;
        fn_alufn = ALUFN_ADD;
        case (fn)
            FN_ADD:   fn_alufn = ALUFN_ADD;
            FN_SUB:   fn_alufn = ALUFN_SUB;
            FN_MUL:   fn_alufn = ALUFN_MUL;
            FN_CMPEQ: fn_alufn = ALUFN_CMPEQ;
            FN_CMPLT: fn_alufn = ALUFN_CMPLT;
            FN_CMPLE: fn_alufn = ALUFN_CMPLE;
            FN_AND:   fn_alufn = ALUFN_AND;
            FN_OR:    fn_alufn = ALUFN_OR;
            FN_XOR:   fn_alufn = ALUFN_XOR;
            FN_SHL:   fn_alufn = ALUFN_SHL;
            FN_SHR:   fn_alufn = ALUFN_SHR;
            FN_SRA:   fn_alufn = ALUFN_SRA;
            default:  fn_ok    = 1'b0;
        endcase
    end

    always_comb begin
        bundle_next = '0;
        if (opcode[5] && fn_ok) begin
            // opcode[4] separates OP (register b) from OPC (literal b)
            bundle_next.alufn = fn_alufn;
            bundle_next.a     = ra_val;
            bundle_next.b     = opcode[4] ? lit_ext : rb_val;
            bundle_next.rc    = rc_idx;
            bundle_next.wr_en = 1'b1;
        end else if ((opcode == OP_LD) || (opcode == OP_LDR) || (opcode == OP_ST)) begin
            // Memory ops only need the effective address Ra + literal
            bundle_next.alufn = ALUFN_ADD;
            bundle_next.a     = ra_val;
            bundle_next.b     = lit_ext;
            bundle_next.rc    = rc_idx;
            bundle_next.wr_en = (opcode != OP_ST);
        end else begin
            bundle_next.illegal = 1'b1;
        end
    end

    // One-entry pipeline register; in_ready looks straight through to
    // out_ready so a drain and a load can share a cycle.
    assign bus.in_ready = !valid_reg || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            bundle_reg <= '0;
        end else if (load) begin
            valid_reg  <= 1'b1;
            bundle_reg <= bundle_next;
        end else if (bus.out_ready) begin
            valid_reg  <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_reg;
    assign bus.out_alufn   = bundle_reg.alufn;
    assign bus.out_a       = bundle_reg.a;
    assign bus.out_b       = bundle_reg.b;
    assign bus.out_rc      = bundle_reg.rc;
    assign bus.out_wr_en   = bundle_reg.wr_en;
    assign bus.out_illegal = bundle_reg.illegal;
endmodule

// File: tb/tb_alu_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed bench for alu_operand_stage: reset values, a decode vector table,
// backpressure, same-cycle write/read, R31 and a mid-stream reset.
// Honours ALU_OPERAND_BYPASS_EN for the same-cycle write/read expectation.
// ----------------------------------------------------------------------------
module tb_alu_operand_stage;
    logic        clk;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total;
    int bad;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  alufn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rc;
        logic        wr_en;
        logic        illegal;
    } vec_t;

    vec_t vecs [18];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [15:0] low);
        return {op, rc, ra, low};
    endfunction

    function automatic logic [15:0] rb(input logic [4:0] r);
        return {r, 11'b0};
    endfunction

    function automatic vec_t v(input logic [31:0] instr, input logic [5:0] alufn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rc, input logic wr_en,
                               input logic illegal);
        vec_t r;
        r.instr = instr; r.alufn = alufn; r.a = a; r.b = b;
        r.rc = rc; r.wr_en = wr_en; r.illegal = illegal;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        $display("wb R%0d <= %h", addr, data);
    endtask

    // Issue one instruction with out_ready=1 and return after it is loaded.
    task automatic issue(input logic [31:0] instr);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] exp_byp;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;

        // Vector table (R1=ffffff68, R2=ffffff34 are written before use)
        vecs[0]  = v(mk(6'b100000, 5'd3,  5'd1,  rb(5'd2)), 6'b000000, 32'hffffff68, 32'hffffff34, 5'd3,  1, 0);
        vecs[1]  = v(mk(6'b110001, 5'd4,  5'd1,  16'hff34), 6'b000001, 32'hffffff68, 32'hffffff34, 5'd4,  1, 0);
        vecs[2]  = v(mk(6'b100010, 5'd5,  5'd2,  rb(5'd1)), 6'b000010, 32'hffffff34, 32'hffffff68, 5'd5,  1, 0);
        vecs[3]  = v(mk(6'b100100, 5'd6,  5'd1,  rb(5'd1)), 6'b110011, 32'hffffff68, 32'hffffff68, 5'd6,  1, 0);
        vecs[4]  = v(mk(6'b110101, 5'd6,  5'd2,  16'h0005), 6'b110101, 32'hffffff34, 32'h00000005, 5'd6,  1, 0);
        vecs[5]  = v(mk(6'b100110, 5'd7,  5'd31, rb(5'd2)), 6'b110111, 32'h00000000, 32'hffffff34, 5'd7,  1, 0);
        vecs[6]  = v(mk(6'b101000, 5'd8,  5'd1,  rb(5'd31)),6'b011000, 32'hffffff68, 32'h00000000, 5'd8,  1, 0);
        vecs[7]  = v(mk(6'b111001, 5'd9,  5'd2,  16'h0012), 6'b011110, 32'hffffff34, 32'h00000012, 5'd9,  1, 0);
        vecs[8]  = v(mk(6'b101010, 5'd10, 5'd1,  rb(5'd2)), 6'b010110, 32'hffffff68, 32'hffffff34, 5'd10, 1, 0);
        vecs[9]  = v(mk(6'b111100, 5'd11, 5'd1,  16'h0004), 6'b100000, 32'hffffff68, 32'h00000004, 5'd11, 1, 0);
        vecs[10] = v(mk(6'b101101, 5'd12, 5'd2,  rb(5'd1)), 6'b100001, 32'hffffff34, 32'hffffff68, 5'd12, 1, 0);
        vecs[11] = v(mk(6'b111110, 5'd13, 5'd1,  16'h7fff), 6'b100011, 32'hffffff68, 32'h00007fff, 5'd13, 1, 0);
        vecs[12] = v(mk(6'b011000, 5'd14, 5'd2,  16'h8000), 6'b000000, 32'hffffff34, 32'hffff8000, 5'd14, 1, 0);
        vecs[13] = v(mk(6'b011001, 5'd15, 5'd1,  16'h0010), 6'b000000, 32'hffffff68, 32'h00000010, 5'd15, 0, 0);
        vecs[14] = v(mk(6'b011111, 5'd16, 5'd31, 16'hfffc), 6'b000000, 32'h00000000, 32'hfffffffc, 5'd16, 1, 0);
        vecs[15] = v(mk(6'b000000, 5'd17, 5'd1,  rb(5'd2)), 6'b000000, 32'h00000000, 32'h00000000, 5'd0,  0, 1);
        vecs[16] = v(mk(6'b100011, 5'd18, 5'd1,  rb(5'd2)), 6'b000000, 32'h00000000, 32'h00000000, 5'd0,  0, 1);
        vecs[17] = v(mk(6'b111111, 5'd19, 5'd2,  16'h1234), 6'b000000, 32'h00000000, 32'h00000000, 5'd0,  0, 1);

        // Reset values
        #2;
        chk("rst out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst out_alufn",   32'(bus.out_alufn),   32'd0);
        chk("rst out_a",       bus.out_a,            32'd0);
        chk("rst out_b",       bus.out_b,            32'd0);
        chk("rst out_rc",      32'(bus.out_rc),      32'd0);
        chk("rst out_wr_en",   32'(bus.out_wr_en),   32'd0);
        chk("rst out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst in_ready",    32'(bus.in_ready),    32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wb_write(5'd1, 32'hffffff68);
        wb_write(5'd2, 32'hffffff34);

        // Decode table
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].instr);
            $display("vec %0d instr=%h alufn=%b a=%h b=%h rc=%0d wr=%b ill=%b",
                     i, vecs[i].instr, bus.out_alufn, bus.out_a, bus.out_b,
                     bus.out_rc, bus.out_wr_en, bus.out_illegal);
            chk($sformatf("vec%0d valid", i),   32'(bus.out_valid),   32'd1);
            chk($sformatf("vec%0d alufn", i),   32'(bus.out_alufn),   32'(vecs[i].alufn));
            chk($sformatf("vec%0d a", i),       bus.out_a,            vecs[i].a);
            chk($sformatf("vec%0d b", i),       bus.out_b,            vecs[i].b);
            if (!vecs[i].illegal)
                chk($sformatf("vec%0d rc", i),  32'(bus.out_rc),      32'(vecs[i].rc));
            chk($sformatf("vec%0d wr_en", i),   32'(bus.out_wr_en),   32'(vecs[i].wr_en));
            chk($sformatf("vec%0d illegal", i), 32'(bus.out_illegal), 32'(vecs[i].illegal));
        end
        @(posedge clk);
        #1;
        chk("drain out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: A held for 3 cycles while B waits, then B and C flow
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk(6'b100000, 5'd3, 5'd1, rb(5'd2));
        @(posedge clk);
        #1;
        bus.in_instr  = mk(6'b100001, 5'd8, 5'd2, rb(5'd1));
        for (int c = 0; c < 3; c++) begin
            $display("stall cycle %0d in_ready=%b out_rc=%0d", c, bus.in_ready, bus.out_rc);
            chk($sformatf("stall%0d in_ready", c),  32'(bus.in_ready),  32'd0);
            chk($sformatf("stall%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d out_rc", c),    32'(bus.out_rc),    32'd3);
            chk($sformatf("stall%0d out_a", c),     bus.out_a,          32'hffffff68);
            chk($sformatf("stall%0d out_b", c),     bus.out_b,          32'hffffff34);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        $display("release B out_rc=%0d alufn=%b", bus.out_rc, bus.out_alufn);
        chk("B out_valid", 32'(bus.out_valid), 32'd1);
        chk("B out_rc",    32'(bus.out_rc),    32'd8);
        chk("B out_alufn", 32'(bus.out_alufn), 32'b000001);
        chk("B out_a",     bus.out_a,          32'hffffff34);
        bus.in_instr = mk(6'b101001, 5'd9, 5'd1, rb(5'd2));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("C out_rc=%0d alufn=%b", bus.out_rc, bus.out_alufn);
        chk("C out_valid", 32'(bus.out_valid), 32'd1);
        chk("C out_rc",    32'(bus.out_rc),    32'd9);
        chk("C out_alufn", 32'(bus.out_alufn), 32'b011110);
        @(posedge clk);
        #1;
        chk("after C out_valid", 32'(bus.out_valid), 32'd0);

        // Same-cycle write to R5 and CMPEQ R5,R5
`ifdef ALU_OPERAND_BYPASS_EN
        exp_byp = 32'h0a0a0a0a;
`else
        exp_byp = 32'h00000000;
`endif
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0a0a0a0a;
        bus.in_valid = 1'b1;
        bus.in_instr = mk(6'b100100, 5'd10, 5'd5, rb(5'd5));
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        bus.in_valid = 1'b0;
        $display("bypass CMPEQ a=%h b=%h", bus.out_a, bus.out_b);
        chk("bypass a",     bus.out_a,          exp_byp);
        chk("bypass b",     bus.out_b,          exp_byp);
        chk("bypass alufn", 32'(bus.out_alufn), 32'b110011);
        issue(mk(6'b100100, 5'd10, 5'd5, rb(5'd5)));
        $display("R5 reread a=%h b=%h", bus.out_a, bus.out_b);
        chk("R5 reread a", bus.out_a, 32'h0a0a0a0a);
        chk("R5 reread b", bus.out_b, 32'h0a0a0a0a);

        // R31 write is ignored
        wb_write(5'd31, 32'hdeadbeef);
        issue(mk(6'b100000, 5'd11, 5'd31, rb(5'd31)));
        $display("R31 read a=%h b=%h", bus.out_a, bus.out_b);
        chk("R31 a", bus.out_a, 32'h0);
        chk("R31 b", bus.out_b, 32'h0);

        // Reset while a bundle is held
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk(6'b110000, 5'd12, 5'd1, 16'h0001);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("pre-rst out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid-stream reset out_valid=%b out_a=%h", bus.out_valid, bus.out_a);
        chk("mrst out_valid",   32'(bus.out_valid),   32'd0);
        chk("mrst out_alufn",   32'(bus.out_alufn),   32'd0);
        chk("mrst out_a",       bus.out_a,            32'd0);
        chk("mrst out_b",       bus.out_b,            32'd0);
        chk("mrst out_rc",      32'(bus.out_rc),      32'd0);
        chk("mrst out_wr_en",   32'(bus.out_wr_en),   32'd0);
        chk("mrst out_illegal", 32'(bus.out_illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post-rst out_valid", 32'(bus.out_valid), 32'd0);
        issue(mk(6'b100000, 5'd3, 5'd1, rb(5'd2)));
        $display("post-rst ADD a=%h b=%h", bus.out_a, bus.out_b);
        chk("post-rst regs a", bus.out_a, 32'h0);
        chk("post-rst regs b", bus.out_b, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
